// File: rtl/pe_pkg.sv
// Shared definitions for the PE datapath (bit-shift stage and partial-sum accumulator).
package pe_pkg;

    localparam int PE_PROD_W      = 19;
    localparam int PE_KERNEL_SIZE = 9;
    localparam int PE_ACC_W       = 24;

    // Width needed to hold a term count of 0..kernel_size inclusive
    function automatic int cnt_width(input int kernel_size);
        return $clog2(kernel_size + 1);
    endfunction

    localparam int PE_CNT_W = cnt_width(PE_KERNEL_SIZE);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } psum_state_e;

endpackage

// File: rtl/psum_term_counter.sv
// Window term counter: counts accepted slots, wraps after KERNEL_SIZE terms and
// flags the slot that completes the window. Clear takes priority over accept.
module psum_term_counter
    import pe_pkg::*;
#(
    parameter int KERNEL_SIZE = PE_KERNEL_SIZE,
    parameter int CNT_W       = cnt_width(KERNEL_SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_W'(KERNEL_SIZE - 1));
    assign last_o  = accept_i && !clear_i && at_last;
    assign cnt_o   = cnt_q;

    // Next count: clear or window completion return to zero
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (accept_i) begin
            cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums KERNEL_SIZE signed shifted products per window and
// presents the result with a one-cycle valid pulse. Skipped slots count as zero.
// Optional build macro PSUM_RELU_EN clamps negative window sums to zero on output.
module psum_accumulator
    import pe_pkg::*;
#(
    parameter int KERNEL_SIZE = PE_KERNEL_SIZE,
    parameter int PROD_W      = PE_PROD_W,
    parameter int ACC_W       = PE_ACC_W,
    parameter int CNT_W       = cnt_width(KERNEL_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic              i_skip,
    input  logic [PROD_W-1:0] i_product,
    input  logic              i_clear,
    output logic [ACC_W-1:0]  o_psum,
    output logic              o_valid,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_term_cnt
);

    psum_state_e             state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] psum_q, psum_d;
    logic                    valid_q, valid_d;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] sum;
    logic                    last;
    logic [CNT_W-1:0]        cnt;

    psum_term_counter #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .CNT_W       (CNT_W)
    ) u_term_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept_i (i_valid),
        .clear_i  (i_clear),
        .cnt_o    (cnt),
        .last_o   (last)
    );

    assign term = i_skip ? '0 : ACC_W'(signed'(i_product));
    assign sum  = acc_q + term;

    // Next-state, accumulator and output-register update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        psum_d  = psum_q;
        valid_d = 1'b0;
        if (i_clear) begin
            state_d = IDLE;
            acc_d   = '0;
        end else if (i_valid) begin
            case (state_q)
                IDLE: begin
                    acc_d   = term;
                    state_d = ACCUM;
                end
                ACCUM: begin
                    if (last) begin
`ifdef PSUM_RELU_EN
                        psum_d = sum[ACC_W-1] ? '0 : sum;
`else
                        psum_d = sum;
`endif
                        valid_d = 1'b1;
                        acc_d   = '0;
                        state_d = IDLE;
                    end else begin
                        acc_d = sum;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            psum_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            psum_q  <= psum_d;
            valid_q <= valid_d;
        end
    end

    assign o_psum     = psum_q;
    assign o_valid    = valid_q;
    assign o_term_cnt = cnt;
    assign o_busy     = (cnt != '0);

endmodule
